// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetches 16-bit words from a synchronous instruction memory,
// decodes fields and sequences program flow. Optional macro IF_PC_WRAP_EN wraps the PC at end of memory.
module instr_fetch #(
  parameter int IMEM_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_re,
  input  logic [15:0]        imem_data,
  output logic [2:0]         op_code,
  output logic [3:0]         ra1,
  output logic [3:0]         ra2,
  output logic [3:0]         wa,
  output logic               op_valid,
  output logic [IMEM_AW-1:0] pc,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALT} state_t;

  localparam logic [IMEM_AW-1:0] LAST_ADDR = '1;

  state_t             state_reg, state_next;
  logic [IMEM_AW-1:0] fetch_ptr_reg, fetch_ptr_next;
  logic [IMEM_AW-1:0] pc_reg, pc_next;
  logic [15:0]        ir_reg, ir_next;
  logic               illegal_reg, illegal_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      fetch_ptr_reg <= '0;
      pc_reg        <= '0;
      ir_reg        <= '0;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_ptr_reg <= fetch_ptr_next;
      pc_reg        <= pc_next;
      ir_reg        <= ir_next;
      illegal_reg   <= illegal_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    fetch_ptr_next = fetch_ptr_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    illegal_next   = illegal_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          fetch_ptr_next = '0;
          state_next     = FETCH;
        end
      end
      FETCH: state_next = WAIT;
      WAIT: begin
        ir_next        = imem_data;
        pc_next        = fetch_ptr_reg;
        fetch_ptr_next = fetch_ptr_reg + IMEM_AW'(1);
        // Undefined opcodes never reach ISSUE, so op_valid can never expose them.
        case (imem_data[15:13])
          3'b111:        state_next = HALT;
          3'b101, 3'b110: begin
            state_next   = HALT;
            illegal_next = 1'b1;
          end
          default:       state_next = ISSUE;
        endcase
      end
      ISSUE: begin
        if (!stall) begin
`ifdef IF_PC_WRAP_EN
          state_next = FETCH;
`else
          state_next = (pc_reg == LAST_ADDR) ? HALT : FETCH;
`endif
        end
      end
      HALT: begin
        if (start) begin
          illegal_next   = 1'b0;
          fetch_ptr_next = '0;
          state_next     = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit 0 of the instruction word is reserved.
  logic ir_unused;
  assign ir_unused = ir_reg[0];

  assign imem_re   = (state_reg == FETCH);
  assign imem_addr = fetch_ptr_reg;
  assign op_valid  = (state_reg == ISSUE);
  assign halted    = (state_reg == HALT);
  assign illegal   = illegal_reg;
  assign pc        = pc_reg;
  assign op_code   = ir_reg[15:13];
  assign ra1       = ir_reg[12:9];
  assign ra2       = ir_reg[8:5];
  assign wa        = ir_reg[4:1];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed latency/stall/halt/reset steps plus
// random programs checked cycle-by-cycle against a program-flow reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [4:0]  imem_addr;
  logic        imem_re;
  logic [15:0] imem_data = '0;
  logic [2:0]  op_code;
  logic [3:0]  ra1, ra2, wa;
  logic        op_valid;
  logic [4:0]  pc;
  logic        halted, illegal;

  logic [15:0] mem [0:31];
  int tests = 0;
  int fails = 0;

  instr_fetch #(.IMEM_AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .imem_addr(imem_addr), .imem_re(imem_re), .imem_data(imem_data),
    .op_code(op_code), .ra1(ra1), .ra2(ra2), .wa(wa),
    .op_valid(op_valid), .pc(pc), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the read request.
  always @(posedge clk) if (imem_re) imem_data <= mem[imem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [15:0] w, input int a);
    check({tag, "_op"},  32'(op_code), 32'(w[15:13]));
    check({tag, "_ra1"}, 32'(ra1),     32'(w[12:9]));
    check({tag, "_ra2"}, 32'(ra2),     32'(w[8:5]));
    check({tag, "_wa"},  32'(wa),      32'(w[4:1]));
    check({tag, "_pc"},  32'(pc),      32'(a));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_op"},   32'(op_code),   0);
    check({tag, "_ra1"},  32'(ra1),       0);
    check({tag, "_ra2"},  32'(ra2),       0);
    check({tag, "_wa"},   32'(wa),        0);
    check({tag, "_ov"},   32'(op_valid),  0);
    check({tag, "_pc"},   32'(pc),        0);
    check({tag, "_hlt"},  32'(halted),    0);
    check({tag, "_ill"},  32'(illegal),   0);
    check({tag, "_re"},   32'(imem_re),   0);
    check({tag, "_addr"}, 32'(imem_addr), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; start = 1'b0;
    #1 check_reset("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    repeat (2) begin
      @(negedge clk);
      check({tag, "_re"}, 32'(imem_re),  0);
      check({tag, "_ov"}, 32'(op_valid), 0);
      check({tag, "_hlt"}, 32'(halted),  0);
    end
  endtask

  // Reference model: walk the program from address 0, one FETCH, one WAIT and
  // one-or-more ISSUE cycles per legal instruction; halts on 111/101/110 or end of memory.
  task automatic run_prog(input int stall_pct, input int max_stall, input int max_instr,
                          output bit ended_halted);
    int a, n, ns;
    logic [15:0] w;
    bit s;
    a = 0; n = 0; ended_halted = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!ended_halted) begin
      check("fetch_re",   32'(imem_re),   1);
      check("fetch_addr", 32'(imem_addr), 32'(a));
      check("fetch_ov",   32'(op_valid),  0);
      check("fetch_hlt",  32'(halted),    0);
      check("fetch_ill",  32'(illegal),   0);
      if (n >= max_instr) break;
      start = 1'($urandom_range(1));
      @(negedge clk);
      check("wait_re",  32'(imem_re),  0);
      check("wait_ov",  32'(op_valid), 0);
      check("wait_hlt", 32'(halted),   0);
      start = 1'($urandom_range(1));
      @(negedge clk);
      w = mem[a];
      $display("[TB] instr addr=%0d word=%04h op=%0d", a, w, w[15:13]);
      if (w[15:13] >= 3'd5) begin
        start = 1'b0;
        check_fields("halt", w, a);
        check("halt_hlt", 32'(halted),   1);
        check("halt_ill", 32'(illegal),  (w[15:13] != 3'd7) ? 1 : 0);
        check("halt_ov",  32'(op_valid), 0);
        check("halt_re",  32'(imem_re),  0);
        ended_halted = 1;
      end else begin
        ns = 0;
        do begin
          check("iss_ov",  32'(op_valid), 1);
          check("iss_re",  32'(imem_re),  0);
          check("iss_hlt", 32'(halted),   0);
          check_fields("iss", w, a);
          s = (ns < max_stall) && ($urandom_range(99) < stall_pct);
          if (s) ns++;
          stall = s;
          start = 1'($urandom_range(1));
          @(negedge clk);
        end while (s);
        stall = 1'b0;
        n++;
        if (a == 31) begin
`ifdef IF_PC_WRAP_EN
          a = 0;
`else
          start = 1'b0;
          check("end_hlt", 32'(halted),   1);
          check("end_ill", 32'(illegal),  0);
          check("end_ov",  32'(op_valid), 0);
          check("end_re",  32'(imem_re),  0);
          ended_halted = 1;
`endif
        end else begin
          a++;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    bit hl;
    logic [15:0] w;
    int r;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    #1 check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Latency: start at edge N, imem_re in N+1, op_valid with decoded fields in N+2.
    mem[0] = 16'h2468; mem[1] = 16'h4321; mem[2] = 16'hE000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_re_c1",   32'(imem_re),   1);
    check("lat_addr_c1", 32'(imem_addr), 0);
    @(negedge clk);
    check("lat_ov_c1",   32'(op_valid),  0);
    @(negedge clk);
    check("lat_ov_c2",   32'(op_valid),  1);
    check("lat_op",      32'(op_code),   1);
    check("lat_ra1",     32'(ra1),       2);
    check("lat_ra2",     32'(ra2),       3);
    check("lat_wa",      32'(wa),        4);
    check("lat_pc",      32'(pc),        0);
    do_reset();

    // Four stall cycles per instruction, then HALT opcode at address 2.
    run_prog(100, 4, 100, hl);
    check("halt2_ended", 32'(hl), 1);
    // Restart from HALT; opcode 101 at address 1 traps.
    mem[1] = 16'hA000;
    run_prog(0, 0, 100, hl);
    check("ill_ended", 32'(hl), 1);
    // Restart must clear illegal; opcode 110 also traps.
    mem[1] = 16'hC123;
    run_prog(20, 3, 100, hl);

    // Random programs.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 32; i++) begin
        w = 16'($urandom);
        r = $urandom_range(99);
        w[15:13] = (r < 92) ? 3'($urandom_range(4)) : 3'($urandom_range(7, 5));
        mem[i] = w;
      end
      run_prog(30, 3, 40, hl);
      if (!hl) do_reset();
    end

    // All opcode 000: wraps to address 0 on the 33rd fetch, or halts after address 31.
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom) & 16'h1FFF;
    run_prog(0, 0, 32, hl);
`ifdef IF_PC_WRAP_EN
    check("wrap_no_halt", 32'(hl), 0);
    do_reset();
`else
    check("nowrap_halt", 32'(hl), 1);
`endif

    // Asynchronous reset while in WAIT.
    mem[0] = 16'h2468;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    check_idle("idle_after_wait");

    // Asynchronous reset while stalled in ISSUE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    check("stall_ov_a", 32'(op_valid), 1);
    @(negedge clk);
    check("stall_ov_b", 32'(op_valid), 1);
    check("stall_op",   32'(op_code),  1);
    rst = 1'b1;
    #1 check_reset("rst_issue");
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle("idle_after_issue");

    // Normal operation after reset.
    mem[1] = 16'hE000;
    run_prog(0, 0, 100, hl);
    check("post_rst_halt", 32'(hl), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
